// File: rtl/collision_scheduler.sv
// Frame-synchronous collision arbiter: one shared box-overlap comparator scans ship+4 shots vs 4 rocks.
// Optional ship invulnerability window after a hit is enabled by defining COLLIDE_GRACE_EN.
module collision_scheduler #(
  parameter int unsigned SHIP_R  = 48,
  parameter int unsigned SHOT_R  = 32,
  parameter int unsigned SCORE_W = 16
`ifdef COLLIDE_GRACE_EN
  , parameter int unsigned GRACE_FRAMES = 120
`endif
) (
  input  logic               clk,
  input  logic               rst_imp,
  input  logic               vs,
  input  logic [9:0]         ship_x,
  input  logic [9:0]         ship_y,
  input  logic [39:0]        rock_x,
  input  logic [39:0]        rock_y,
  input  logic [39:0]        shot_x,
  input  logic [39:0]        shot_y,
  input  logic [3:0]         rock_active,
  input  logic [3:0]         shot_active,
  output logic [3:0]         reset_rocks,
  output logic [3:0]         reset_shots,
  output logic               reset_ship,
  output logic               hit,
  output logic [SCORE_W-1:0] score,
  output logic               busy,
  output logic               overrun,
  output logic               grace_active
);

  localparam int unsigned CW      = 10;
  localparam int unsigned PW      = 5;
  localparam int unsigned SUM_W   = SCORE_W + 3;
  localparam logic [PW-1:0] LAST_PAIR = PW'(19);

  typedef enum logic [1:0] {IDLE, LATCH, SCAN, COMMIT} state_t;

  state_t        state;
  logic          vs_s1, vs_s2, vs_s3;
  logic          vs_edge;
  logic [PW-1:0] pair;

  logic [CW-1:0] ship_x_q, ship_y_q;
  logic [39:0]   rock_x_q, rock_y_q, shot_x_q, shot_y_q;
  logic [3:0]    rock_act_q, shot_act_q;

  logic [3:0]    rock_flag, shot_flag, kill_flag;
  logic          ship_flag;
  logic          grace_block;

  logic [2:0]    obj;
  logic [1:0]    rk, sh;
  logic          is_ship;
  logic [CW-1:0] ax, ay, bx, by, dx, dy, radius;
  logic          overlap, pair_ok, pair_hit;

  logic [2:0]         kill_cnt;
  logic [SUM_W-1:0]   score_sum;
  logic [SCORE_W-1:0] score_next;

  assign vs_edge = vs_s2 & ~vs_s3;

  // Current pair decode and unsigned, non-wrapping box-overlap test
  always_comb begin
    obj     = pair[4:2];
    rk      = pair[1:0];
    is_ship = (obj == 3'd0);
    sh      = 2'(obj - 3'd1);
    ax      = is_ship ? ship_x_q : shot_x_q[sh*CW +: CW];
    ay      = is_ship ? ship_y_q : shot_y_q[sh*CW +: CW];
    bx      = rock_x_q[rk*CW +: CW];
    by      = rock_y_q[rk*CW +: CW];
    dx      = (ax >= bx) ? ax - bx : bx - ax;
    dy      = (ay >= by) ? ay - by : by - ay;
    radius  = is_ship ? CW'(SHIP_R) : CW'(SHOT_R);
    overlap = (dx <= radius) && (dy <= radius);
    pair_ok = rock_act_q[rk] && !rock_flag[rk] &&
              (is_ship ? !grace_block : (shot_act_q[sh] && !shot_flag[sh]));
    pair_hit = pair_ok && overlap;
  end

  // Saturating score update from rocks killed by shots this frame
  always_comb begin
    kill_cnt   = 3'(kill_flag[0]) + 3'(kill_flag[1]) + 3'(kill_flag[2]) + 3'(kill_flag[3]);
    score_sum  = SUM_W'(score) + SUM_W'(kill_cnt);
    score_next = (score_sum[SUM_W-1:SCORE_W] != '0) ? '1 : score_sum[SCORE_W-1:0];
  end

  always_ff @(posedge clk or posedge rst_imp) begin
    if (rst_imp) begin
      state       <= IDLE;
      vs_s1       <= 1'b0;
      vs_s2       <= 1'b0;
      vs_s3       <= 1'b0;
      pair        <= '0;
      ship_x_q    <= '0;
      ship_y_q    <= '0;
      rock_x_q    <= '0;
      rock_y_q    <= '0;
      shot_x_q    <= '0;
      shot_y_q    <= '0;
      rock_act_q  <= '0;
      shot_act_q  <= '0;
      rock_flag   <= '0;
      shot_flag   <= '0;
      kill_flag   <= '0;
      ship_flag   <= 1'b0;
      reset_rocks <= '0;
      reset_shots <= '0;
      reset_ship  <= 1'b0;
      hit         <= 1'b0;
      score       <= '0;
      busy        <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      vs_s1       <= vs;
      vs_s2       <= vs_s1;
      vs_s3       <= vs_s2;
      reset_rocks <= '0;
      reset_shots <= '0;
      reset_ship  <= 1'b0;
      hit         <= 1'b0;
      if (vs_edge && state != IDLE) overrun <= 1'b1;
      case (state)
        IDLE: begin
          if (vs_edge) begin
            state <= LATCH;
            busy  <= 1'b1;
          end
        end
        LATCH: begin
          ship_x_q   <= ship_x;
          ship_y_q   <= ship_y;
          rock_x_q   <= rock_x;
          rock_y_q   <= rock_y;
          shot_x_q   <= shot_x;
          shot_y_q   <= shot_y;
          rock_act_q <= rock_active;
          shot_act_q <= shot_active;
          rock_flag  <= '0;
          shot_flag  <= '0;
          kill_flag  <= '0;
          ship_flag  <= 1'b0;
          pair       <= '0;
          state      <= SCAN;
        end
        SCAN: begin
          // Ship pairs come first, so a rock the ship hits is gone before shots see it
          if (pair_hit) begin
            rock_flag[rk] <= 1'b1;
            if (is_ship) begin
              ship_flag <= 1'b1;
            end else begin
              shot_flag[sh] <= 1'b1;
              kill_flag[rk] <= 1'b1;
            end
          end
          if (pair == LAST_PAIR) state <= COMMIT;
          else                   pair  <= pair + PW'(1);
        end
        COMMIT: begin
          reset_rocks <= rock_flag;
          reset_shots <= shot_flag;
          reset_ship  <= ship_flag;
          hit         <= |kill_flag;
          score       <= score_next;
          busy        <= 1'b0;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef COLLIDE_GRACE_EN
  localparam int unsigned GW = 16;

  logic [GW-1:0] grace_cnt;
  logic [GW-1:0] grace_next;

  assign grace_block = (grace_cnt != '0);

  // Reload on a ship hit, otherwise count frames down to zero
  always_comb begin
    grace_next = grace_cnt;
    if (ship_flag)               grace_next = GW'(GRACE_FRAMES);
    else if (grace_cnt != '0)    grace_next = grace_cnt - GW'(1);
  end

  always_ff @(posedge clk or posedge rst_imp) begin
    if (rst_imp) begin
      grace_cnt    <= '0;
      grace_active <= 1'b0;
    end else if (state == COMMIT) begin
      grace_cnt    <= grace_next;
      grace_active <= (grace_next != '0);
    end
  end
`else
  assign grace_block  = 1'b0;
  assign grace_active = 1'b0;
`endif

endmodule

// File: tb/tb_collision_scheduler.sv
// Scoreboard bench for collision_scheduler: directed frames push expected commits,
// a negedge monitor pops and compares whenever the scan finishes.
module tb_collision_scheduler;

  localparam int unsigned SW  = 4;
  localparam int unsigned LAT = 25;

  logic          clk = 1'b0;
  logic          rst_imp;
  logic          vs;
  logic [9:0]    ship_x, ship_y;
  logic [39:0]   rock_x, rock_y, shot_x, shot_y;
  logic [3:0]    rock_active, shot_active;
  logic [3:0]    reset_rocks, reset_shots;
  logic          reset_ship, hit, busy, overrun, grace_active;
  logic [SW-1:0] score;

  typedef struct {
    logic [3:0]    rocks;
    logic [3:0]    shots;
    logic          ship;
    logic          hit;
    logic [SW-1:0] score;
    int            cyc;
  } exp_t;

  exp_t expq[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   exp_score = 0;

  collision_scheduler #(
`ifdef COLLIDE_GRACE_EN
    .SCORE_W(SW), .GRACE_FRAMES(2)
`else
    .SCORE_W(SW)
`endif
  ) dut (
    .clk(clk), .rst_imp(rst_imp), .vs(vs),
    .ship_x(ship_x), .ship_y(ship_y),
    .rock_x(rock_x), .rock_y(rock_y), .shot_x(shot_x), .shot_y(shot_y),
    .rock_active(rock_active), .shot_active(shot_active),
    .reset_rocks(reset_rocks), .reset_shots(reset_shots), .reset_ship(reset_ship),
    .hit(hit), .score(score), .busy(busy), .overrun(overrun), .grace_active(grace_active)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  // Monitor: the commit cycle is the first cycle after busy drops
  initial begin
    logic prev_busy = 1'b0;
    logic post = 1'b0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_imp) begin
        prev_busy = 1'b0;
        post = 1'b0;
      end else begin
        if (post) begin
          chk("pulse_width", 32'({reset_rocks, reset_shots, reset_ship, hit}), 32'(0));
          post = 1'b0;
        end
        if (prev_busy && !busy) begin
          if (expq.size() == 0) begin
            chk("unexpected_commit", 32'(1), 32'(0));
          end else begin
            e = expq.pop_front();
            chk("reset_rocks", 32'(reset_rocks), 32'(e.rocks));
            chk("reset_shots", 32'(reset_shots), 32'(e.shots));
            chk("reset_ship",  32'(reset_ship),  32'(e.ship));
            chk("hit",         32'(hit),         32'(e.hit));
            chk("score",       32'(score),       32'(e.score));
            chk("latency",     32'(cyc),         32'(e.cyc));
          end
          post = 1'b1;
        end
        prev_busy = busy;
      end
    end
  end

  task automatic clear_inputs();
    ship_x = 10'd1000; ship_y = 10'd1000;
    rock_x = '0; rock_y = '0; shot_x = '0; shot_y = '0;
    rock_active = '0; shot_active = '0;
  endtask

  task automatic set_rock(input int i, input int x, input int y, input logic act);
    rock_x[i*10 +: 10] = 10'(x);
    rock_y[i*10 +: 10] = 10'(y);
    rock_active[i] = act;
  endtask

  task automatic set_shot(input int i, input int x, input int y, input logic act);
    shot_x[i*10 +: 10] = 10'(x);
    shot_y[i*10 +: 10] = 10'(y);
    shot_active[i] = act;
  endtask

  // Raise vs for two cycles; optionally push the expected commit of this frame
  task automatic start_frame(input logic push, input logic [3:0] rocks, input logic [3:0] shots,
                             input logic ship, input logic h, input int kills);
    exp_t e;
    @(negedge clk);
    if (push) begin
      exp_score = (exp_score + kills > 15) ? 15 : exp_score + kills;
      e.rocks = rocks; e.shots = shots; e.ship = ship; e.hit = h;
      e.score = SW'(exp_score); e.cyc = cyc + LAT;
      expq.push_back(e);
    end
    vs = 1'b1;
    repeat (2) @(negedge clk);
    vs = 1'b0;
  endtask

  task automatic run_frame(input logic [3:0] rocks, input logic [3:0] shots,
                           input logic ship, input logic h, input int kills);
    start_frame(1'b1, rocks, shots, ship, h, kills);
    repeat (30) @(negedge clk);
  endtask

  task automatic settle();
`ifdef COLLIDE_GRACE_EN
    @(negedge clk); rst_imp = 1'b1;
    @(negedge clk); rst_imp = 1'b0;
    exp_score = 0;
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_imp = 1'b1; vs = 1'b0;
    clear_inputs();
    repeat (3) @(negedge clk);
    chk("rst_outputs", 32'({reset_rocks, reset_shots, reset_ship, hit, busy, overrun, grace_active}), 32'(0));
    chk("rst_score", 32'(score), 32'(0));
    rst_imp = 1'b0;
    repeat (2) @(negedge clk);

`ifdef COLLIDE_GRACE_EN
    // Grace window of two frames after a ship hit
    clear_inputs();
    ship_x = 10'd100; ship_y = 10'd100;
    set_rock(0, 148, 52, 1'b1);
    run_frame(4'b0001, 4'b0000, 1'b1, 1'b0, 0);
    chk("grace_on", 32'(grace_active), 32'(1));
    run_frame(4'b0000, 4'b0000, 1'b0, 1'b0, 0);
    chk("grace_f1", 32'(grace_active), 32'(1));
    run_frame(4'b0000, 4'b0000, 1'b0, 1'b0, 0);
    chk("grace_f2", 32'(grace_active), 32'(0));
    run_frame(4'b0001, 4'b0000, 1'b1, 1'b0, 0);
    chk("grace_f3", 32'(grace_active), 32'(1));
    settle();
`endif

    // Ship vs rock at exactly the ship half-window
    clear_inputs();
    ship_x = 10'd100; ship_y = 10'd100;
    set_rock(0, 148, 52, 1'b1);
    run_frame(4'b0001, 4'b0000, 1'b1, 1'b0, 0);
`ifndef COLLIDE_GRACE_EN
    chk("grace_tied0", 32'(grace_active), 32'(0));
`endif
    settle();

    // Shot1 overlaps rocks 1 and 2 at the shot boundary; lower rock wins
    clear_inputs();
    ship_x = 10'd600; ship_y = 10'd400;
    set_rock(1, 300, 200, 1'b1);
    set_rock(2, 300, 200, 1'b1);
    set_shot(1, 332, 168, 1'b1);
    run_frame(4'b0010, 4'b0010, 1'b0, 1'b1, 1);

    // Near-origin difference without underflow
    clear_inputs();
    ship_x = 10'd10; ship_y = 10'd10;
    set_rock(0, 0, 0, 1'b1);
    run_frame(4'b0001, 4'b0000, 1'b1, 1'b0, 0);
    settle();

    // Far apart; inactive overlapping objects ignored; late input change ignored
    clear_inputs();
    ship_x = 10'd0; ship_y = 10'd0;
    set_rock(0, 1000, 1000, 1'b1);
    set_rock(1, 0, 0, 1'b0);
    set_shot(0, 1000, 1000, 1'b0);
    start_frame(1'b1, 4'b0000, 4'b0000, 1'b0, 1'b0, 0);
    repeat (4) @(negedge clk);
    ship_x = 10'd1000; ship_y = 10'd1000;
    shot_active = 4'b0001; rock_active = 4'b0011;
    repeat (26) @(negedge clk);

    // Ship and shot0 both on rock3: the ship consumes it
    clear_inputs();
    ship_x = 10'd200; ship_y = 10'd200;
    set_rock(3, 220, 220, 1'b1);
    set_shot(0, 230, 230, 1'b1);
    run_frame(4'b1000, 4'b0000, 1'b1, 1'b0, 0);
    settle();
    chk("overrun_clear", 32'(overrun), 32'(0));

    // Second vs edge mid-scan is dropped and flagged
    clear_inputs();
    set_rock(2, 500, 300, 1'b1);
    set_shot(2, 500, 300, 1'b1);
    start_frame(1'b1, 4'b0100, 4'b0100, 1'b0, 1'b1, 1);
    repeat (8) @(negedge clk);
    vs = 1'b1;
    repeat (2) @(negedge clk);
    vs = 1'b0;
    repeat (30) @(negedge clk);
    chk("overrun_set", 32'(overrun), 32'(1));

    // Four kills per frame drive the score into saturation
    clear_inputs();
    for (int i = 0; i < 4; i++) begin
      set_rock(i, 100 + 100*i, 300, 1'b1);
      set_shot(i, 100 + 100*i, 300, 1'b1);
    end
    for (int f = 0; f < 5; f++) run_frame(4'b1111, 4'b1111, 1'b0, 1'b1, 4);
    chk("score_sat", 32'(score), 32'(15));

    // Reset during the scan at pair 7 aborts the frame
    start_frame(1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 0);
    repeat (9) @(negedge clk);
    chk("busy_in_scan", 32'(busy), 32'(1));
    rst_imp = 1'b1;
    exp_score = 0;
    repeat (2) @(negedge clk);
    chk("abort_outputs", 32'({reset_rocks, reset_shots, reset_ship, hit, busy, overrun}), 32'(0));
    chk("abort_score", 32'(score), 32'(0));
    rst_imp = 1'b0;
    repeat (30) @(negedge clk);
    chk("abort_idle", 32'({reset_rocks, reset_shots, reset_ship, hit, busy}), 32'(0));

    chk("queue_drained", 32'(expq.size()), 32'(0));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
